rpn_lan_node_finder_stream: RTL and testbench
=============================================

# rpn_lan_node_finder_stream

Multi-beat, parametrised successor of the single-beat LAN node finder, between Control's to-LAN AXI-Stream and the Network Bridge LAN TX interface. It resolves each packet's destination kernel (first-beat tdest) to a node number through the kernel-to-node ROM, and tolerates a configurable ROM read latency. Packet beats are buffered while the lookup is in flight, and the whole packet is forwarded with tuser replaced by the node number.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 64, stream data width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_LAN_TDEST_WIDTH, 8, tid/tdest width (kernel ID).
- AXIS_LAN_TUSER_WIDTH, 16, tuser width.
- NODE_ID_WIDTH, 16, node number width; must be ≤ AXIS_LAN_TUSER_WIDTH.
- BRAM_ADDR_WIDTH, 32, ROM byte address width; must be ≥ AXIS_LAN_TDEST_WIDTH+2.
- ROM_LATENCY, 1, cycles from ROM_EN to valid DOUT; legal range 1..4.
- FIFO_DEPTH, 16, beat buffer depth; power of two, ≥ 2.

Ports:
- i_clk  in  1  clock.
- i_ap_rst_n  in  1  reset; asynchronous, active-low; clock i_clk.
- from_ctrl_LAN_tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast  in (tready out)  1/1/DATA/KEEP/TDEST/TDEST/TUSER/1  upstream stream; incoming tuser is ignored.
- to_LAN_TX_tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast  out (tready in)  same widths  downstream stream.
- kernel_to_node_ROM_CLK, _RST, _EN  out  1  ROM clock (= i_clk), reset (= ~i_ap_rst_n), read enable.
- kernel_to_node_ROM_ADDR  out  BRAM_ADDR_WIDTH  byte address.
- kernel_to_node_ROM_DOUT  in  NODE_ID_WIDTH  node number.
- o_dropped_count  out  16  unmapped packets dropped; saturating.

## Operation
- FSM states: IDLE, LOOKUP, FORWARD.
- IDLE:
  - FIFO is empty; from_ctrl_LAN_tready=1.
  - On a tvalid handshake, the first beat is written to the FIFO and ROM_EN pulses for that cycle.
  - ROM_ADDR = {zeros, tdest, 2'b00}.
  - The wait counter loads ROM_LATENCY-1, and the FSM moves to LOOKUP.
- LOOKUP:
  - The wait counter decrements each cycle.
  - When the counter is 0, ROM_DOUT is captured into the node register and the FSM moves to FORWARD.
- FORWARD:
  - The FIFO head drives the output; to_LAN_TX_tuser = zero-extended node register.
  - tdata, tkeep, tid, tdest and tlast come from the stored beat.
  - The FSM returns to IDLE on the output handshake of a beat with tlast=1.
- Input acceptance in LOOKUP/FORWARD: tready = FIFO not full AND the current packet's tlast not yet accepted.
  - Beats of the next packet stall until the FSM re-enters IDLE.
- ROM_EN is asserted only in the IDLE accept cycle. Otherwise ROM_EN=0 and ROM_ADDR holds its last value.
- FIFO wrap-around: pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB comparison.
- Simultaneous FIFO write and read when full is not allowed (tready is already 0). When empty, a write is not visible on the output in the same cycle.

## Timing
- Reset values (asynchronous): FSM in IDLE, FIFO empty, node register 0, o_dropped_count 0.
  - All to_LAN_TX_* outputs 0; ROM_EN 0; from_ctrl_LAN_tready 0 while reset is asserted.
- First-beat latency: accepted at cycle 0, to_LAN_TX_tvalid first high at cycle ROM_LATENCY+1. For ROM_LATENCY=1 this is 2 cycles.
- Steady state: 1 beat/cycle through FORWARD when downstream tready=1 and the FIFO is non-empty.
- to_LAN_TX_tvalid may drop mid-packet if the FIFO empties.
- While tvalid=1 and tready=0, all output fields stay stable.
- Minimum gap between packets: one IDLE cycle (plus lookup) after the last-beat handshake.
- Reset mid-packet: the FIFO contents and the partial packet are discarded; no beat is emitted after reset release until a new packet is accepted.

## Configuration
- Macro: RPN_LAN_NODE_FINDER_UNMAPPED_DROP_EN.
- Defined:
  - A captured node number of all ones (the unmapped marker) makes FORWARD drain the FIFO internally, with to_LAN_TX_tvalid held 0.
  - The input tready rules are unchanged.
  - The FSM returns to IDLE once the tlast beat has been both accepted and drained.
  - o_dropped_count increments by 1 per dropped packet and saturates at 0xFFFF.
- Undefined: an all-ones node number is forwarded like any other value, and o_dropped_count is tied to 0.

## Test plan
- Single-beat packet, tdest=0x05, ROM returns 0x0003, ROM_LATENCY=1 -> ROM_ADDR=0x14 with ROM_EN for 1 cycle; output tvalid at cycle 2, tuser=0x0003, tlast=1, tdata/tkeep/tid/tdest unchanged.
- 8-beat packet, ROM_LATENCY=3, downstream tready=1 -> first output beat at cycle 4; beats emitted in order; tuser constant on all 8 beats; tlast only on beat 8.
- FIFO_DEPTH=4, 10-beat packet, downstream tready held 0 for 20 cycles -> input tready drops after 4 beats buffered; no loss or duplication after release.
- Two back-to-back packets, second mapping to a different node -> second first-beat stalls until the first tlast handshake; each packet carries its own tuser.
- Reset asserted mid-packet (beat 3 of 6) -> outputs 0 immediately; after release, the next packet is forwarded cleanly with no stale beats.
- With RPN_LAN_NODE_FINDER_UNMAPPED_DROP_EN: ROM returns 0xFFFF for a 3-beat packet -> no output tvalid, o_dropped_count=1; the following mapped packet is forwarded normally.

Source files
------------

// File: rtl/rpn_lan_node_finder_stream.sv
// -----------------------------------------------------------------------------
// rpn_lan_node_finder_stream
//
// Sits between Control's to-LAN AXI-Stream and the Network Bridge LAN TX
// interface. The first beat of each packet carries the destination kernel in
// tdest. That kernel ID is looked up in the kernel-to-node ROM, which has a
// read latency of ROM_LATENCY cycles. Beats are buffered in a small FIFO while
// the lookup is in flight. The whole packet is then forwarded with tuser set
// to the node number.
//
// Ports:
//   i_clk, i_ap_rst_n        clock, asynchronous active-low reset
//   from_ctrl_LAN_*          upstream AXI-Stream (incoming tuser is ignored)
//   to_LAN_TX_*              downstream AXI-Stream, tuser = node number
//   kernel_to_node_ROM_*     ROM clock/reset/enable/byte address/data out
//   o_dropped_count          saturating count of dropped unmapped packets
//
// Optional feature (macro RPN_LAN_NODE_FINDER_UNMAPPED_DROP_EN):
//   When the macro is defined, a node number of all ones marks the kernel as
//   unmapped. Such a packet is drained from the FIFO and never presented
//   downstream, and it is counted in o_dropped_count. When the macro is not
//   defined, all-ones is forwarded like any other node number and the count
//   stays at 0.
//
// State | meaning
// IDLE    | FIFO empty, waiting for the first beat of a packet
// LOOKUP  | ROM read in flight, beats of the packet are buffered
// FORWARD | node known, FIFO head is presented downstream
// -----------------------------------------------------------------------------
module rpn_lan_node_finder_stream #(
  parameter int AXIS_DATA_WIDTH      = 64,
  parameter int AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_LAN_TDEST_WIDTH = 8,
  parameter int AXIS_LAN_TUSER_WIDTH = 16,
  parameter int NODE_ID_WIDTH        = 16,
  parameter int BRAM_ADDR_WIDTH      = 32,
  parameter int ROM_LATENCY          = 1,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                            i_clk,
  input  logic                            i_ap_rst_n,

  input  logic                            from_ctrl_LAN_tvalid,
  output logic                            from_ctrl_LAN_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]      from_ctrl_LAN_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]      from_ctrl_LAN_tkeep,
  input  logic [AXIS_LAN_TDEST_WIDTH-1:0] from_ctrl_LAN_tid,
  input  logic [AXIS_LAN_TDEST_WIDTH-1:0] from_ctrl_LAN_tdest,
  input  logic [AXIS_LAN_TUSER_WIDTH-1:0] from_ctrl_LAN_tuser,
  input  logic                            from_ctrl_LAN_tlast,

  output logic                            to_LAN_TX_tvalid,
  input  logic                            to_LAN_TX_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      to_LAN_TX_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]      to_LAN_TX_tkeep,
  output logic [AXIS_LAN_TDEST_WIDTH-1:0] to_LAN_TX_tid,
  output logic [AXIS_LAN_TDEST_WIDTH-1:0] to_LAN_TX_tdest,
  output logic [AXIS_LAN_TUSER_WIDTH-1:0] to_LAN_TX_tuser,
  output logic                            to_LAN_TX_tlast,

  output logic                            kernel_to_node_ROM_CLK,
  output logic                            kernel_to_node_ROM_RST,
  output logic                            kernel_to_node_ROM_EN,
  output logic [BRAM_ADDR_WIDTH-1:0]      kernel_to_node_ROM_ADDR,
  input  logic [NODE_ID_WIDTH-1:0]        kernel_to_node_ROM_DOUT,

  output logic [15:0]                     o_dropped_count
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int KEEP_LSB  = AXIS_DATA_WIDTH;
  localparam int ID_LSB    = KEEP_LSB + AXIS_KEEP_WIDTH;
  localparam int DEST_LSB  = ID_LSB + AXIS_LAN_TDEST_WIDTH;
  localparam int LAST_BIT  = DEST_LSB + AXIS_LAN_TDEST_WIDTH;
  localparam int ENT_W     = LAST_BIT + 1;
  localparam logic [PTR_W:0] PTR_ONE  = 1;
  localparam logic [1:0]     WAIT_LD  = 2'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FORWARD} state_t;

  state_t                       r_state;
  logic [PTR_W:0]               r_wr_ptr;
  logic [PTR_W:0]               r_rd_ptr;
  logic [ENT_W-1:0]             r_mem [FIFO_DEPTH];
  logic [1:0]                   r_wait;
  logic [NODE_ID_WIDTH-1:0]     r_node;
  logic                         r_last_acc;
  logic [BRAM_ADDR_WIDTH-1:0]   r_rom_addr;

  logic                         w_empty;
  logic                         w_full;
  logic                         w_in_fire;
  logic                         w_rom_en;
  logic                         w_rd;
  logic                         w_drop;
  logic                         w_out_valid;
  logic                         w_head_last;
  logic [ENT_W-1:0]             w_head;
  logic [ENT_W-1:0]             w_entry;
  logic [BRAM_ADDR_WIDTH-1:0]   w_rom_addr_new;
  logic                         w_unused;

  // Incoming tuser is replaced by the node number and never stored.
  assign w_unused = ^from_ctrl_LAN_tuser;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // Once the current packet's tlast is in, the next packet must wait for IDLE
  // so that its first beat is the one used for the lookup.
  assign from_ctrl_LAN_tready = i_ap_rst_n &&
                                ((r_state == S_IDLE) || (!w_full && !r_last_acc));
  assign w_in_fire = from_ctrl_LAN_tvalid && from_ctrl_LAN_tready;
  assign w_rom_en  = w_in_fire && (r_state == S_IDLE);

  always_comb begin
    w_rom_addr_new = '0;
    w_rom_addr_new[AXIS_LAN_TDEST_WIDTH+1:2] = from_ctrl_LAN_tdest;
  end

  assign w_entry = {from_ctrl_LAN_tlast, from_ctrl_LAN_tdest, from_ctrl_LAN_tid,
                    from_ctrl_LAN_tkeep, from_ctrl_LAN_tdata};
  assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_last = w_head[LAST_BIT];

`ifdef RPN_LAN_NODE_FINDER_UNMAPPED_DROP_EN
  logic [15:0] r_dropped;

  assign w_drop = &r_node;

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_dropped <= '0;
    end else if (w_rd && w_head_last && w_drop && (r_dropped != 16'hFFFF)) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

  assign o_dropped_count = r_dropped;
`else
  assign w_drop          = 1'b0;
  assign o_dropped_count = '0;
`endif

  // A dropped packet is drained regardless of downstream tready.
  assign w_rd        = (r_state == S_FORWARD) && !w_empty && (w_drop || to_LAN_TX_tready);
  assign w_out_valid = (r_state == S_FORWARD) && !w_empty && !w_drop;

  assign to_LAN_TX_tvalid = w_out_valid;
  assign to_LAN_TX_tdata  = w_out_valid ? w_head[AXIS_DATA_WIDTH-1:0] : '0;
  assign to_LAN_TX_tkeep  = w_out_valid ? w_head[ID_LSB-1:KEEP_LSB] : '0;
  assign to_LAN_TX_tid    = w_out_valid ? w_head[DEST_LSB-1:ID_LSB] : '0;
  assign to_LAN_TX_tdest  = w_out_valid ? w_head[LAST_BIT-1:DEST_LSB] : '0;
  assign to_LAN_TX_tuser  = w_out_valid ? AXIS_LAN_TUSER_WIDTH'(r_node) : '0;
  assign to_LAN_TX_tlast  = w_out_valid && w_head_last;

  assign kernel_to_node_ROM_CLK  = i_clk;
  assign kernel_to_node_ROM_RST  = ~i_ap_rst_n;
  assign kernel_to_node_ROM_EN   = w_rom_en;
  assign kernel_to_node_ROM_ADDR = w_rom_en ? w_rom_addr_new : r_rom_addr;

  always_ff @(posedge i_clk) begin
    if (w_in_fire) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wait     <= '0;
      r_node     <= '0;
      r_last_acc <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      if (w_in_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd)      r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_state    <= S_LOOKUP;
            r_wait     <= WAIT_LD;
            r_last_acc <= from_ctrl_LAN_tlast;
            r_rom_addr <= w_rom_addr_new;
          end
        end
        S_LOOKUP: begin
          if (w_in_fire && from_ctrl_LAN_tlast) r_last_acc <= 1'b1;
          if (r_wait == 2'd0) begin
            r_node  <= kernel_to_node_ROM_DOUT;
            r_state <= S_FORWARD;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_FORWARD: begin
          if (w_in_fire && from_ctrl_LAN_tlast) r_last_acc <= 1'b1;
          // The tlast beat leaving the FIFO is the last one of the packet, since
          // input is blocked after tlast is accepted.
          if (w_rd && w_head_last) begin
            r_state    <= S_IDLE;
            r_last_acc <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_lan_node_finder_stream.sv
module tb_rpn_lan_node_finder_stream;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [15:0] user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic [7:0]  in_id = '0;
  logic [7:0]  in_dest = '0;
  logic [15:0] in_user = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic [7:0]  out_id;
  logic [7:0]  out_dest;
  logic [15:0] out_user;
  logic        out_last;
  logic        rom_clk;
  logic        rom_rst;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [15:0] rom_dout;
  logic [15:0] dropped;

  int    tests_run = 0;
  int    fails = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    acc_count = 0;
  int    sop_cyc = 0;
  int    eop_cyc = 0;
  int    out_beats = 0;
  logic  in_pkt = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_got;
  beat_t sb[$];

  logic [15:0] rom_tbl [256];
  logic [15:0] rom_pipe [LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rpn_lan_node_finder_stream #(
    .ROM_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk                   (clk),
    .i_ap_rst_n              (rst_n),
    .from_ctrl_LAN_tvalid    (in_valid),
    .from_ctrl_LAN_tready    (in_ready),
    .from_ctrl_LAN_tdata     (in_data),
    .from_ctrl_LAN_tkeep     (in_keep),
    .from_ctrl_LAN_tid       (in_id),
    .from_ctrl_LAN_tdest     (in_dest),
    .from_ctrl_LAN_tuser     (in_user),
    .from_ctrl_LAN_tlast     (in_last),
    .to_LAN_TX_tvalid        (out_valid),
    .to_LAN_TX_tready        (out_ready),
    .to_LAN_TX_tdata         (out_data),
    .to_LAN_TX_tkeep         (out_keep),
    .to_LAN_TX_tid           (out_id),
    .to_LAN_TX_tdest         (out_dest),
    .to_LAN_TX_tuser         (out_user),
    .to_LAN_TX_tlast         (out_last),
    .kernel_to_node_ROM_CLK  (rom_clk),
    .kernel_to_node_ROM_RST  (rom_rst),
    .kernel_to_node_ROM_EN   (rom_en),
    .kernel_to_node_ROM_ADDR (rom_addr),
    .kernel_to_node_ROM_DOUT (rom_dout),
    .o_dropped_count         (dropped)
  );

  // ROM model: data appears LAT cycles after the enable cycle and holds.
  always @(posedge rom_clk) begin
    if (rom_rst) begin
      for (int i = 0; i < LAT; i++) rom_pipe[i] <= '0;
    end else begin
      if (rom_en) rom_pipe[0] <= rom_tbl[rom_addr[9:2]];
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
  end
  assign rom_dout = rom_pipe[LAT-1];

  // Output monitor: scoreboard pop/compare and stall-stability check.
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    got = '{d: out_data, k: out_keep, id: out_id, dest: out_dest, user: out_user, last: out_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
      in_pkt     = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (got !== prev_got) begin
          fails++;
          $display("FAIL stall_stable got=%h required=%h", got, prev_got);
        end
      end
      if (out_valid && !in_pkt) begin
        sop_cyc = cyc;
        in_pkt  = 1'b1;
      end
      if (out_valid && out_ready) begin
        out_beats++;
        tests_run++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat got=%h required=none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL beat got=%h required=%h", got, exp);
          end
        end
        if (out_last) begin
          in_pkt  = 1'b0;
          eop_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_got   = got;
    end
  end

  task automatic drive_beat(input logic [7:0] dest, input logic [63:0] data, input logic [7:0] keep,
                            input logic last, input logic first, input logic push);
    int    n;
    logic  done;
    beat_t e;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_keep  = keep;
    in_id    = dest ^ 8'h3C;
    in_dest  = dest;
    in_user  = 16'($urandom);
    in_last  = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        acc_count++;
        if (first) acc_cyc = cyc;
        if (push) begin
          e = '{d: data, k: keep, id: dest ^ 8'h3C, dest: dest, user: rom_tbl[dest], last: last};
          sb.push_back(e);
        end
      end else begin
        n++;
        if (n > 300) begin
          tests_run++;
          fails++;
          $display("FAIL in_accept_timeout got=no_tready required=tready");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] dest, input int n, input logic [31:0] seed);
    logic push;
    push = 1'b1;
`ifdef RPN_LAN_NODE_FINDER_UNMAPPED_DROP_EN
    push = (rom_tbl[dest] != 16'hFFFF);
`endif
    for (int i = 0; i < n; i++)
      drive_beat(dest, {seed, 32'(i)}, 8'(8'hFF >> (i % 8)), i == n - 1, i == 0, push);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_pkt) && n < 400) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (sb.size() != 0 || in_pkt) begin
      fails++;
      $display("FAIL drain_timeout got=%0d_pending required=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_dest  = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, out_data, out_user, out_last} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b/%h/%h/%b required=0", out_valid, out_data, out_user, out_last);
    end
    tests_run++;
    if (in_ready !== 1'b0 || rom_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_en got=%b/%b required=0/0", in_ready, rom_en);
    end
    tests_run++;
    if (dropped !== 16'h0) begin
      fails++;
      $display("FAIL reset_dropped got=%h required=0000", dropped);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    beat_t e;
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0123_4567;
    in_keep  = 8'h3F;
    in_id    = 8'h9A;
    in_dest  = 8'h05;
    in_user  = 16'h7777;
    in_last  = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 32'h14) begin
      fails++;
      $display("FAIL single_rom_req got=%b/%b/%h required=1/1/00000014", in_ready, rom_en, rom_addr);
    end
    acc_cyc = cyc;
    e = '{d: 64'hDEAD_BEEF_0123_4567, k: 8'h3F, id: 8'h9A, dest: 8'h05, user: 16'h0003, last: 1'b1};
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rom_en !== 1'b0 || rom_addr !== 32'h14) begin
      fails++;
      $display("FAIL single_rom_hold got=%b/%h required=0/00000014", rom_en, rom_addr);
    end
    wait_drain();
    tests_run++;
    if (sop_cyc - acc_cyc !== LAT + 1) begin
      fails++;
      $display("FAIL single_latency got=%0d required=%0d", sop_cyc - acc_cyc, LAT + 1);
    end
  endtask

  task automatic test_burst8();
    int start_beats;
    out_ready   = 1'b1;
    start_beats = out_beats;
    send_pkt(8'h40, 8, 32'hA0A0_0001);
    wait_drain();
    tests_run++;
    if (sop_cyc - acc_cyc !== LAT + 1) begin
      fails++;
      $display("FAIL burst_latency got=%0d required=%0d", sop_cyc - acc_cyc, LAT + 1);
    end
    tests_run++;
    if (out_beats - start_beats !== 8) begin
      fails++;
      $display("FAIL burst_count got=%0d required=8", out_beats - start_beats);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    acc_count = 0;
    fork
      send_pkt(8'h21, 10, 32'hB0B0_0002);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (acc_count !== DEPTH || in_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_fill got=%0d/%b required=%0d/0", acc_count, in_ready, DEPTH);
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp_valid got=%b required=1", out_valid);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    tests_run++;
    if (acc_count !== 10) begin
      fails++;
      $display("FAIL bp_total got=%0d required=10", acc_count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_pkt(8'h11, 3, 32'hC0C0_0003);
    send_pkt(8'h22, 2, 32'hC0C0_0004);
    tests_run++;
    if (acc_cyc !== eop_cyc + 1) begin
      fails++;
      $display("FAIL b2b_stall got=%0d required=%0d", acc_cyc, eop_cyc + 1);
    end
    wait_drain();
  endtask

  task automatic test_random_ready();
    logic done;
    done = 1'b0;
    fork
      begin
        send_pkt(8'h31, 5, 32'hD0D0_0005);
        send_pkt(8'h32, 1, 32'hD0D0_0006);
        send_pkt(8'h33, 7, 32'hD0D0_0007);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive_beat(8'h44, {32'hE0E0_0008, 32'(i)}, 8'hFF, 1'b0, i == 0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_valid_before got=%b required=1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    tests_run++;
    if ({out_valid, out_data, out_user, out_last, in_ready} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs got=%b/%h/%h/%b/%b required=0", out_valid, out_data, out_user, out_last, in_ready);
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL mid_stale_beats got=%0d required=0", seen);
    end
    @(posedge clk);
    #1;
    send_pkt(8'h07, 4, 32'hE0E0_0009);
    wait_drain();
  endtask

  task automatic test_unmapped();
    int start_beats;
    out_ready   = 1'b1;
    start_beats = out_beats;
    send_pkt(8'hEE, 3, 32'hF0F0_000A);
`ifdef RPN_LAN_NODE_FINDER_UNMAPPED_DROP_EN
    repeat (15) @(posedge clk);
    #1;
    tests_run++;
    if (dropped !== 16'h0001) begin
      fails++;
      $display("FAIL drop_count got=%h required=0001", dropped);
    end
    tests_run++;
    if (out_beats !== start_beats) begin
      fails++;
      $display("FAIL drop_no_output got=%0d required=0", out_beats - start_beats);
    end
`else
    wait_drain();
    tests_run++;
    if (dropped !== 16'h0 || out_beats - start_beats !== 3) begin
      fails++;
      $display("FAIL allones_forward got=%h/%0d required=0000/3", dropped, out_beats - start_beats);
    end
`endif
    send_pkt(8'h05, 2, 32'hF0F0_000B);
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_tbl[i] = 16'h0100 + 16'(i);
    rom_tbl[8'h05] = 16'h0003;
    rom_tbl[8'hEE] = 16'hFFFF;
    test_reset();
    test_single();
    test_burst8();
    test_backpressure();
    test_back_to_back();
    test_random_ready();
    test_reset_mid();
    test_unmapped();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
